// File: rtl/riscv_dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package riscv_dmem_arbiter_pkg;

   // Default data/address width of the core.
   localparam int unsigned DMEM_XLEN = 32;

   // Width of the external-port starvation counter.
   localparam int unsigned WAIT_W = 4;

   // Arbitration FSM states.
   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_CPU      = 2'd1,
      ARB_EXT      = 2'd2,
      ARB_EXT_LOCK = 2'd3
   } arb_state_e;

   // A granted access launches a read response only when it is a load.
   function automatic logic rd_launch(input logic gnt, input logic wr_en);
      return gnt & ~wr_en;
   endfunction

endpackage

// File: rtl/riscv_dmem_arbiter_reg.sv
// Data register with load enable and asynchronous active-low clear.
module riscv_dmem_arbiter_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] data_d, data_q;

   // Hold the current value unless a new word is being loaded.
   always_comb begin
      data_d = data_q;
      if (i_en) data_d = i_d;
   end

   // Storage; cleared asynchronously.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) data_q <= '0;
      else         data_q <= data_d;
   end

   assign o_q = data_q;

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Two-port data-memory arbiter: CPU-first priority with a starvation bound for the
// external master, locked bursts, and one-cycle registered read responses.
module riscv_dmem_arbiter
   import riscv_dmem_arbiter_pkg::*;
#(
   parameter int unsigned XLEN         = DMEM_XLEN,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   // CPU load/store port
   input  logic            i_cpu_req,
   input  logic            i_cpu_wr_en,
   input  logic [XLEN-1:0] i_cpu_addr,
   input  logic [3:0]      i_cpu_byte_sel,
   input  logic [XLEN-1:0] i_cpu_wr_data,
   output logic            o_cpu_gnt,
   output logic            o_cpu_stall,
   output logic [XLEN-1:0] o_cpu_rd_data,
   output logic            o_cpu_rd_valid,
   // External master port
   input  logic            i_ext_req,
   input  logic            i_ext_wr_en,
   input  logic [XLEN-1:0] i_ext_addr,
   input  logic [3:0]      i_ext_byte_sel,
   input  logic [XLEN-1:0] i_ext_wr_data,
   input  logic            i_ext_lock,
   output logic            o_ext_gnt,
   output logic [XLEN-1:0] o_ext_rd_data,
   output logic            o_ext_rd_valid,
   // Data memory
   output logic [XLEN-1:0] o_mem_addr,
   output logic            o_mem_wr_en,
   output logic [3:0]      o_mem_byte_sel,
   output logic [XLEN-1:0] o_mem_wr_data,
   input  logic [XLEN-1:0] i_mem_rd_data
);

   localparam logic [WAIT_W-1:0] StarveLim = WAIT_W'(STARVE_LIMIT);

   arb_state_e        state_d, state_q;
   logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;
   logic              cpu_rd_valid_d, cpu_rd_valid_q;
   logic              ext_rd_valid_d, ext_rd_valid_q;
   logic              cpu_gnt, ext_gnt;
   logic              cpu_rd_en, ext_rd_en;

   // Grant decision and next state; a held lock bypasses normal arbitration.
   always_comb begin
      cpu_gnt = 1'b0;
      ext_gnt = 1'b0;
      state_d = ARB_IDLE;

      if (state_q == ARB_EXT_LOCK && i_ext_lock) begin
         ext_gnt = i_ext_req;
      end else if (i_cpu_req && i_ext_req) begin
         if (wait_cnt_q == StarveLim) ext_gnt = 1'b1;
         else                         cpu_gnt = 1'b1;
      end else if (i_cpu_req) begin
         cpu_gnt = 1'b1;
      end else if (i_ext_req) begin
         ext_gnt = 1'b1;
      end

      if (ext_gnt) begin
         state_d = i_ext_lock ? ARB_EXT_LOCK : ARB_EXT;
      end else if (cpu_gnt) begin
         state_d = ARB_CPU;
      end else if (state_q == ARB_EXT_LOCK && i_ext_lock) begin
         // Request gap inside a locked burst keeps ownership.
         state_d = ARB_EXT_LOCK;
      end
   end

   // Starvation counter: counts denied external cycles, saturating at the limit.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!i_ext_req || ext_gnt) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q < StarveLim) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   // Read-response launch for each port.
   always_comb begin
      cpu_rd_en      = rd_launch(cpu_gnt, i_cpu_wr_en);
      ext_rd_en      = rd_launch(ext_gnt, i_ext_wr_en);
      cpu_rd_valid_d = cpu_rd_en;
      ext_rd_valid_d = ext_rd_en;
   end

   // Memory mux: the granted port drives the memory; idle bus is quiet.
   always_comb begin
      o_mem_addr     = '0;
      o_mem_wr_en    = 1'b0;
      o_mem_byte_sel = 4'b0000;
      o_mem_wr_data  = '0;
      if (ext_gnt) begin
         o_mem_addr     = i_ext_addr;
         o_mem_wr_en    = i_ext_wr_en;
         o_mem_byte_sel = i_ext_byte_sel;
         o_mem_wr_data  = i_ext_wr_data;
      end else if (cpu_gnt) begin
         o_mem_addr     = i_cpu_addr;
         o_mem_wr_en    = i_cpu_wr_en;
         o_mem_byte_sel = i_cpu_byte_sel;
         o_mem_wr_data  = i_cpu_wr_data;
      end
   end

   // FSM state, starvation counter and response-valid flags.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q        <= ARB_IDLE;
         wait_cnt_q     <= '0;
         cpu_rd_valid_q <= 1'b0;
         ext_rd_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         cpu_rd_valid_q <= cpu_rd_valid_d;
         ext_rd_valid_q <= ext_rd_valid_d;
      end
   end

   riscv_dmem_arbiter_reg #(
      .WIDTH (XLEN)
   ) u_cpu_rd_data (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_en   (cpu_rd_en),
      .i_d    (i_mem_rd_data),
      .o_q    (o_cpu_rd_data)
   );

   riscv_dmem_arbiter_reg #(
      .WIDTH (XLEN)
   ) u_ext_rd_data (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_en   (ext_rd_en),
      .i_d    (i_mem_rd_data),
      .o_q    (o_ext_rd_data)
   );

   assign o_cpu_gnt      = cpu_gnt;
   assign o_ext_gnt      = ext_gnt;
   assign o_cpu_stall    = i_cpu_req & ~cpu_gnt;
   assign o_cpu_rd_valid = cpu_rd_valid_q;
   assign o_ext_rd_valid = ext_rd_valid_q;

endmodule
